// File: rtl/serpent_dec_if.sv
// rtl/serpent_dec_if.sv - handshake, key-fetch and datapath bundle for serpent_dec_ctrl
interface serpent_dec_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         key_req;
  logic [5:0]   key_idx;
  logic         key_ack;
  logic [127:0] key_data;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic [2:0]   dp_sbox_sel;
  logic         dp_skip_lt;
  logic [127:0] dp_result;
  logic         abort;
  logic         busy;
  logic [15:0]  blk_cnt;

  // Controller side
  modport slave (
    input  in_valid, in_data, out_ready, key_ack, key_data, dp_result, abort,
    output in_ready, out_valid, out_data, key_req, key_idx,
           dp_state, dp_key, dp_sbox_sel, dp_skip_lt, busy, blk_cnt
  );

  // Environment side (block source/sink, key store, datapath)
  modport master (
    output in_valid, in_data, out_ready, key_ack, key_data, dp_result, abort,
    input  in_ready, out_valid, out_data, key_req, key_idx,
           dp_state, dp_key, dp_sbox_sel, dp_skip_lt, busy, blk_cnt
  );
endinterface

// File: rtl/serpent_dec_ctrl.sv
// rtl/serpent_dec_ctrl.sv - Serpent block decryption sequencer over a shared inverse-round datapath
module serpent_dec_ctrl (
  input  logic           clk,
  input  logic           rst,
  serpent_dec_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WHITEN, ROUND, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [4:0]   rnd_q, rnd_d;
  logic [15:0]  blk_cnt_q, blk_cnt_d;

  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         key_req;
  logic [5:0]   key_idx;
  logic [127:0] dp_state;
  logic [127:0] dp_key;
  logic [2:0]   dp_sbox_sel;
  logic         dp_skip_lt;

  // State register: block value, round index, completed-block counter, FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rnd_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  // Next-state and output decode; abort overrides every transition and update
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_d       = rnd_q;
    blk_cnt_d   = blk_cnt_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    key_req     = 1'b0;
    key_idx     = '0;
    dp_state    = '0;
    dp_key      = '0;
    dp_sbox_sel = '0;
    dp_skip_lt  = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        // Ready drops under abort so a visible handshake always means a load
        in_ready = ~rst & ~bus.abort;
        if (bus.in_valid && in_ready) begin
          state_d = bus.in_data;
          fsm_d   = WHITEN;
        end
      end
      WHITEN: begin
        key_req = 1'b1;
        key_idx = 6'd32;
        if (bus.key_ack) begin
          state_d = state_q ^ bus.key_data;
          rnd_d   = 5'd31;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        key_req     = 1'b1;
        key_idx     = {1'b0, rnd_q};
        dp_state    = state_q;
        dp_key      = bus.key_data;
        dp_sbox_sel = rnd_q[2:0];
        // The last encryption round has no linear transform to undo
        dp_skip_lt  = (rnd_q == 5'd31);
        if (bus.key_ack) begin
          state_d = bus.dp_result;
          if (rnd_q == 5'd0) begin
            fsm_d = DONE;
          end else begin
            rnd_d = rnd_q - 5'd1;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = state_q;
        if (bus.out_ready) begin
          blk_cnt_d = blk_cnt_q + 16'd1;
          fsm_d     = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase

    if (bus.abort) begin
      fsm_d     = IDLE;
      state_d   = state_q;
      rnd_d     = rnd_q;
      blk_cnt_d = blk_cnt_q;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data;
  assign bus.key_req     = key_req;
  assign bus.key_idx     = key_idx;
  assign bus.dp_state    = dp_state;
  assign bus.dp_key      = dp_key;
  assign bus.dp_sbox_sel = dp_sbox_sel;
  assign bus.dp_skip_lt  = dp_skip_lt;
  assign bus.busy        = (fsm_q != IDLE);
  assign bus.blk_cnt     = blk_cnt_q;

endmodule

// File: tb/tb_serpent_dec_ctrl.sv
// tb/tb_serpent_dec_ctrl.sv - self-checking bench for serpent_dec_ctrl
module tb_serpent_dec_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serpent_dec_if ifc ();

  serpent_dec_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [127:0] subkey [0:32];

  // ---------------- Serpent reference (bitsliced, word 0 = bits 31:0) ----------------
  function automatic logic [3:0] sb(input int n, input logic [3:0] v);
    logic [63:0] t;
    case (n)
      0: t = 64'hC90724DEB56A1F83;
      1: t = 64'h43D68EB1A50972CF;
      2: t = 64'h25B04E1DFAC39768;
      3: t = 64'hE57A421D369C8BF0;
      4: t = 64'hD7E9A4526B0C38F1;
      5: t = 64'h176D8E30C9A4B25F;
      6: t = 64'h0A3DF19EB6485C27;
      default: t = 64'h6539AC47B28E0FD1;
    endcase
    return t[{v, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sb(input int n, input logic [3:0] v);
    for (int j = 0; j < 16; j++)
      if (sb(n, 4'(j)) == v) return 4'(j);
    return 4'd0;
  endfunction

  function automatic logic [127:0] sbox_layer(input int n, input logic [127:0] x, input bit inv);
    logic [127:0] y;
    logic [3:0]   a, b;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      a = {x[96+i], x[64+i], x[32+i], x[i]};
      b = inv ? inv_sb(n, a) : sb(n, a);
      y[i] = b[0]; y[32+i] = b[1]; y[64+i] = b[2]; y[96+i] = b[3];
    end
    return y;
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] w, input int s);
    return (w << s) | (w >> (32 - s));
  endfunction

  function automatic logic [127:0] lt(input logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = x;
    x0 = rol(x0, 13); x2 = rol(x2, 3);
    x1 = x1 ^ x0 ^ x2; x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rol(x1, 1); x3 = rol(x3, 7);
    x0 = x0 ^ x1 ^ x3; x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rol(x0, 5); x2 = rol(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] inv_lt(input logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = x;
    x2 = rol(x2, 10); x0 = rol(x0, 27);
    x2 = x2 ^ x3 ^ (x1 << 7); x0 = x0 ^ x1 ^ x3;
    x3 = rol(x3, 25); x1 = rol(x1, 31);
    x3 = x3 ^ x2 ^ (x0 << 3); x1 = x1 ^ x0 ^ x2;
    x2 = rol(x2, 29); x0 = rol(x0, 19);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] x;
    x = pt;
    for (int i = 0; i < 32; i++) begin
      x = sbox_layer(i % 8, x ^ subkey[i], 1'b0);
      if (i < 31) x = lt(x);
      else        x = x ^ subkey[32];
    end
    return x;
  endfunction

  // One decryption step consuming subkey r (32 = whitening)
  function automatic logic [127:0] dec_step(input logic [127:0] x, input int r);
    if (r == 32) return x ^ subkey[32];
    return sbox_layer(r % 8, (r == 31) ? x : inv_lt(x), 1'b1) ^ subkey[r];
  endfunction

  // Environment: combinational datapath and key store
  assign ifc.dp_result = sbox_layer(int'(ifc.dp_sbox_sel),
                                    ifc.dp_skip_lt ? ifc.dp_state : inv_lt(ifc.dp_state), 1'b1)
                         ^ ifc.dp_key;
  assign ifc.key_data  = (ifc.key_idx <= 6'd32) ? subkey[ifc.key_idx] : '0;

  // Key responder: 0 = always ack, 1 = random 0..5 cycle stalls
  int ack_mode = 0;
  int stall    = 0;
  always @(negedge clk) begin
    if (ack_mode == 0) begin
      ifc.key_ack = 1'b1;
    end else if (stall == 0) begin
      ifc.key_ack = 1'b1;
      stall = $urandom_range(0, 5);
    end else begin
      ifc.key_ack = 1'b0;
      stall = stall - 1;
    end
  end

  // ---------------- Transaction model: block in flight + subkeys consumed ----------------
  logic         m_active;
  int           m_acks;
  logic [127:0] m_x;
  logic [15:0]  m_blk;
  logic [15:0]  blk_ofs = 16'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_acks <= 0; m_x <= '0; m_blk <= 16'd0;
    end else if (ifc.abort) begin
      m_active <= 1'b0; m_acks <= 0;
    end else if (!m_active) begin
      if (ifc.in_valid) begin
        m_active <= 1'b1; m_acks <= 0; m_x <= ifc.in_data;
      end
    end else if (m_acks < 33) begin
      if (ifc.key_ack) begin
        m_x <= dec_step(m_x, 32 - m_acks);
        m_acks <= m_acks + 1;
      end
    end else if (ifc.out_ready) begin
      m_active <= 1'b0; m_blk <= m_blk + 16'd1;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int   idx;
    logic rnd_ph, kreq, done;
    idx    = 32 - m_acks;
    rnd_ph = m_active && (m_acks >= 1) && (m_acks <= 32);
    kreq   = m_active && (m_acks < 33);
    done   = m_active && (m_acks == 33);
    check("in_ready",  128'(ifc.in_ready),  128'(!m_active && !ifc.abort && !rst));
    check("busy",      128'(ifc.busy),      128'(m_active));
    check("key_req",   128'(ifc.key_req),   128'(kreq));
    check("key_idx",   128'(ifc.key_idx),   kreq ? 128'(idx) : 128'd0);
    check("out_valid", 128'(ifc.out_valid), 128'(done));
    check("out_data",  ifc.out_data,        done ? m_x : 128'd0);
    check("blk_cnt",   128'(ifc.blk_cnt),   128'(16'(m_blk + blk_ofs)));
    check("dp_state",  ifc.dp_state,        rnd_ph ? m_x : 128'd0);
    check("dp_key",    ifc.dp_key,          rnd_ph ? subkey[idx] : 128'd0);
    check("dp_sel",    128'(ifc.dp_sbox_sel), rnd_ph ? 128'(idx % 8) : 128'd0);
    check("dp_skip",   128'(ifc.dp_skip_lt),  128'(rnd_ph && idx == 31));
  endtask

  task automatic start_block(input logic [127:0] ct, input logic ordy);
    @(posedge clk); #1;
    ifc.in_data = ct; ifc.in_valid = 1'b1; ifc.out_ready = ordy;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] pt, input int bp, input bit chk_lat,
                           input logic [15:0] exp_blk);
    int         edges;
    bit         seen;
    int         seq_err;
    logic [5:0] seq [$];
    edges = 0; seen = 0; seq_err = 0;
    start_block(encrypt(pt), (bp == 0));
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (ifc.key_req && (seq.size() == 0 || seq[$] != ifc.key_idx)) begin
        seq.push_back(ifc.key_idx);
        if (ifc.key_idx <= 6'd31 &&
            (ifc.dp_sbox_sel != ifc.key_idx[2:0] || ifc.dp_skip_lt != (ifc.key_idx == 6'd31)))
          seq_err++;
      end
      if (ifc.out_valid) seen = 1;
      else begin @(posedge clk); edges++; end
    end
    check("out_valid_timeout", 128'(seen), 128'd1);
    if (chk_lat) check("latency_33", 128'(edges), 128'd33);
    check("seq_len", 128'(seq.size()), 128'd33);
    foreach (seq[i]) if (seq[i] != 6'(32 - i)) seq_err++;
    check("key_idx_seq_errs", 128'(seq_err), 128'd0);
    check("plaintext", ifc.out_data, pt);
    for (int c = 0; c < bp; c++) begin
      @(negedge clk);
      check("bp_valid", 128'(ifc.out_valid), 128'd1);
      check("bp_data", ifc.out_data, pt);
      check("bp_in_ready", 128'(ifc.in_ready), 128'd0);
      check("bp_blk", 128'(ifc.blk_cnt), 128'(16'(exp_blk - 16'd1)));
    end
    if (bp != 0) begin @(posedge clk); #1; ifc.out_ready = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    check("blk_after", 128'(ifc.blk_cnt), 128'(exp_blk));
    check("idle_after", 128'(ifc.busy), 128'd0);
  endtask

  task automatic watch_no_out(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int c = 0; c < cycles; c++) begin @(negedge clk); if (ifc.out_valid) hits++; end
    check(name, 128'(hits), 128'd0);
  endtask

  initial begin
    logic [127:0] rx;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b1; ifc.abort = 1'b0;
    for (int i = 0; i <= 32; i++) subkey[i] = {$urandom, $urandom, $urandom, $urandom};

    // Hand-derived pins on the reference primitives
    check("pin_inv_s0_3", 128'(inv_sb(0, 4'd3)), 128'd0);
    check("pin_inv_s0_8", 128'(inv_sb(0, 4'd8)), 128'd1);
    check("pin_inv_s7_6", 128'(inv_sb(7, 4'd6)), 128'd15);
    check("pin_sbox_zero", sbox_layer(0, 128'd0, 1'b0), 128'h00000000_00000000_FFFFFFFF_FFFFFFFF);
    check("pin_lt_one", lt(128'd1), 128'h00800000_00002800_00004000_100C0000);
    rx = {$urandom, $urandom, $urandom, $urandom};
    check("pin_lt_roundtrip", inv_lt(lt(rx)), rx);

    fork
      forever begin @(negedge clk); compare_all(); end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(ifc.in_ready), 128'd0);
    check("rst_blk", 128'(ifc.blk_cnt), 128'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 128'(ifc.in_ready), 128'd1);

    ack_mode = 0;
    run_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 0, 1, 16'd1);
    ack_mode = 1;
    run_block(128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE, 0, 0, 16'd2);
    ack_mode = 0;
    run_block({$urandom, $urandom, $urandom, $urandom}, 10, 1, 16'd3);

    // Abort at rnd=17 together with key_ack
    start_block(encrypt(128'h1), 1'b1);
    repeat (15) @(posedge clk);
    #1;
    check("abort_at_idx17", 128'(ifc.key_idx), 128'd17);
    ifc.abort = 1'b1;
    @(posedge clk); #1; ifc.abort = 1'b0;
    check("abort_key_req", 128'(ifc.key_req), 128'd0);
    check("abort_busy", 128'(ifc.busy), 128'd0);
    check("abort_blk", 128'(ifc.blk_cnt), 128'd3);
    watch_no_out("abort_no_out", 40);
    run_block(128'hCAFEF00D_00000000_11111111_76543210, 0, 1, 16'd4);

    // Abort in IDLE alongside in_valid: no load
    @(posedge clk); #1; ifc.in_valid = 1'b1; ifc.abort = 1'b1;
    @(posedge clk); #1; ifc.in_valid = 1'b0; ifc.abort = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", 128'(ifc.busy), 128'd0);

    // Abort in DONE beats out_ready
    start_block(encrypt(128'h2), 1'b0);
    for (int c = 0; c < 100 && !ifc.out_valid; c++) @(negedge clk);
    check("done_reached", 128'(ifc.out_valid), 128'd1);
    @(posedge clk); #1; ifc.abort = 1'b1; ifc.out_ready = 1'b1;
    @(posedge clk); #1; ifc.abort = 1'b0;
    @(negedge clk);
    check("abort_done_valid", 128'(ifc.out_valid), 128'd0);
    check("abort_done_blk", 128'(ifc.blk_cnt), 128'd4);

    // Reset mid-ROUND
    start_block(encrypt(128'h3), 1'b1);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("mid_rst_in_ready", 128'(ifc.in_ready), 128'd0);
    check("mid_rst_busy", 128'(ifc.busy), 128'd0);
    check("mid_rst_key_req", 128'(ifc.key_req), 128'd0);
    check("mid_rst_key_idx", 128'(ifc.key_idx), 128'd0);
    check("mid_rst_out_valid", 128'(ifc.out_valid), 128'd0);
    check("mid_rst_out_data", ifc.out_data, 128'd0);
    check("mid_rst_blk", 128'(ifc.blk_cnt), 128'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_again", 128'(ifc.in_ready), 128'd1);
    watch_no_out("mid_rst_no_out", 40);

    // Counter wrap: preload near the top rather than completing 65534 blocks
    @(posedge clk); #1;
    blk_ofs = 16'hFFFE - m_blk;
    force dut.blk_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.blk_cnt_q;
    run_block(128'h5, 0, 1, 16'hFFFF);
    run_block(128'h6, 0, 1, 16'h0000);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serpent_dec_ctrl.md
SERPENT_DEC_CTRL -- requirements
Module: serpent_dec_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: in_valid input 1, in_ready output 1, in_data input 128; ciphertext block handshake.
REQ-004 SHALL have ports: out_valid output 1, out_ready input 1, out_data output 128; plaintext block handshake.
REQ-005 SHALL have ports: key_req output 1, key_idx output 6, key_ack input 1, key_data input 128; subkey fetch from key store.
REQ-006 SHALL have ports: dp_state output 128, dp_key output 128, dp_sbox_sel output 3, dp_skip_lt output 1, dp_result input 128; shared inverse-round datapath (dp_result = invS[sel](skip_lt ? state : invLT(state)) ^ key, combinational, same cycle).
REQ-007 SHALL have ports: abort input 1, busy output 1, blk_cnt output 16 (completed blocks, wrapping).

Function
REQ-008 SHALL implement FSM states IDLE, WHITEN, ROUND, DONE.
REQ-009 IDLE: in_ready=1; on in_valid&in_ready, state_reg<=in_data, go WHITEN; in_ready=0 in all other states.
REQ-010 WHITEN: key_req=1, key_idx=32; on key_ack, state_reg<=state_reg^key_data, rnd<=31, go ROUND.
REQ-011 ROUND: key_req=1, key_idx=rnd, dp_state=state_reg, dp_key=key_data, dp_sbox_sel=rnd[2:0], dp_skip_lt=(rnd==31); on key_ack, state_reg<=dp_result.
REQ-012 ROUND on key_ack: rnd==0 -> go DONE; else rnd<=rnd-1, stay ROUND.
REQ-013 key_ack SHALL be accepted in the same cycle key_req rises; key_idx SHALL stay stable while key_req=1 and key_ack=0; key_ack with key_req=0 SHALL be ignored.
REQ-014 DONE: out_valid=1, out_data=state_reg; on out_ready, blk_cnt<=blk_cnt+1 (0xFFFF wraps to 0x0000), go IDLE.
REQ-015 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 With key_ack tied 1, out_valid SHALL rise exactly 33 clock edges after the accepting edge (1 whitening + 32 rounds).
REQ-017 busy SHALL be 1 in WHITEN, ROUND, DONE; 0 in IDLE.
REQ-018 abort=1 (synchronous) in any state SHALL return to IDLE next edge, deassert key_req and out_valid, leave blk_cnt unchanged; abort takes priority over key_ack and out_ready in the same cycle.
REQ-019 abort in IDLE coincident with in_valid SHALL block acceptance (no load).
REQ-020 dp_state, dp_key, dp_sbox_sel, dp_skip_lt SHALL be 0 outside ROUND.
REQ-021 key_idx SHALL be 0 when key_req=0.

Reset
REQ-022 rst=1 SHALL immediately force IDLE, state_reg=0, rnd=0, blk_cnt=0, key_req=0, key_idx=0, out_valid=0, out_data=0, busy=0, in_ready=0.
REQ-023 After rst deasserts, in_ready SHALL be 1 from the first cycle onward (IDLE).
REQ-024 rst mid-block SHALL discard the block with no out_valid pulse.

Verification
REQ-025 Test vector: key_ack=1, out_ready=1, in_data=ciphertext of a software Serpent model -> out_data equals the model plaintext 33 edges after acceptance; blk_cnt 0->1.
REQ-026 Sequence check: key_idx over one block = 32,31,...,0; dp_sbox_sel = 7,6,...,0 repeated 4 times; dp_skip_lt=1 only for key_idx=31.
REQ-027 Key stalls: key_ack random 0-5 cycle delays -> same out_data as REQ-025; key_idx never changes while unacked.
REQ-028 Output backpressure: out_ready=0 for 10 cycles -> out_valid held, out_data stable, in_ready=0, blk_cnt unchanged until handshake.
REQ-029 abort asserted at rnd=17 together with key_ack -> IDLE next edge, key_req=0, no out_valid, blk_cnt unchanged; next block decrypts correctly.
REQ-030 rst pulsed mid-ROUND, and blk_cnt preloaded by running 65536 blocks -> reset values per REQ-022; wrap 0xFFFF->0x0000.
